// File: rtl/jt51_pg_mon_if.sv
// Bundle between the phase generator side (phase bus, start request,
// result consumer) and the jt51_pg_mon phase-step monitor.
//
// Handshake: the result is transferred on a clk edge where result_valid and
// result_ready are both high. Once raised, result_valid stays high and
// result/aliased stay stable until that transfer, or until a new start drops
// the pending result.
//
// The alias flag is carried as "aliased" because "alias" is a reserved word in
// SystemVerilog.
interface jt51_pg_mon_if #(
    parameter int WIN_LOG2 = 6
);
    logic                  cen;
    logic                  zero;
    logic [9:0]            phase;
    logic [4:0]            slot_sel;
    logic                  start;
    logic                  busy;
    logic                  result_valid;
    logic                  result_ready;
    logic [WIN_LOG2+9:0]   result;
    logic                  aliased;
    // Debug visibility: FSM state (0 IDLE, 1 ARM, 2 MEASURE, 3 DONE) and slot counter
    logic [1:0]            dbg_state;
    logic [4:0]            dbg_cnt;

    modport master (
        output cen, zero, phase, slot_sel, start, result_ready,
        input  busy, result_valid, result, aliased, dbg_state, dbg_cnt
    );

    modport slave (
        input  cen, zero, phase, slot_sel, start, result_ready,
        output busy, result_valid, result, aliased, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/jt51_pg_mon.sv
// Passive monitor of the time-multiplexed operator phase bus. For one selected
// slot it sums the per-sample phase step over 2^WIN_LOG2 samples and hands the
// sum out through a valid/ready handshake, flagging steps of 512 or more.
module jt51_pg_mon #(
    parameter int WIN_LOG2 = 6,
    parameter int PH_STAGE = 10
) (
    input  logic          clk,
    input  logic          rst,
    jt51_pg_mon_if.slave  bus
);
    localparam int RW = WIN_LOG2 + 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic [4:0]            cnt;
    logic [4:0]            sel_q;
    logic [4:0]            match_slot;
    logic                  match;
    logic [9:0]            prev;
    logic [9:0]            delta;
    logic [RW-1:0]         acc;
    logic [RW-1:0]         acc_next;
    logic [WIN_LOG2-1:0]   count;
    logic                  alias_acc;
    logic                  busy_q;
    logic                  valid_q;
    logic [RW-1:0]         result_q;
    logic                  aliased_q;

    // The phase on the bus lags the zero pulse by PH_STAGE slots, so the
    // selected slot shows up when the counter reads sel_q + PH_STAGE.
    assign match_slot = sel_q + 5'(PH_STAGE);
    assign match      = bus.cen && (cnt == match_slot);
    // Modulo-1024 step; a wrap of the phase accumulator stays a small positive step
    assign delta      = bus.phase - prev;
    assign acc_next   = acc + RW'(delta);

    // Slot counter: follows cen, resynchronised by every zero pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 5'd0;
        end else if (bus.cen) begin
            cnt <= bus.zero ? 5'd0 : cnt + 5'd1;
        end
    end

    // Measurement FSM; start is honoured in every state and always re-arms
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            aliased_q <= 1'b0;
            sel_q     <= 5'd0;
            prev      <= 10'd0;
            acc       <= '0;
            count     <= '0;
            alias_acc <= 1'b0;
        end else if (bus.start) begin
            // New request: any pending result is dropped, partial sums discarded
            state     <= ARM;
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            sel_q     <= bus.slot_sel;
            acc       <= '0;
            count     <= '0;
            alias_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                ARM: begin
                    // First sample only seeds the reference phase
                    if (match) begin
                        prev  <= bus.phase;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (match) begin
                        acc       <= acc_next;
                        count     <= count + WIN_LOG2'(1);
                        prev      <= bus.phase;
                        alias_acc <= alias_acc | delta[9];
                        if (&count) begin
                            result_q  <= acc_next;
                            aliased_q <= alias_acc | delta[9];
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.aliased      = aliased_q;
    assign bus.dbg_state    = state;
    assign bus.dbg_cnt      = cnt;
endmodule

// File: tb/tb_jt51_pg_mon.sv
// Directed bench for jt51_pg_mon: a table of single-slot measurements plus
// hand-written sequences for backpressure, restart, drop-on-start, reset and
// zero resynchronisation.
module tb_jt51_pg_mon;
    localparam int WIN      = 6;
    localparam int PH_STAGE = 10;
    localparam int RW       = WIN + 10;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    jt51_pg_mon_if #(.WIN_LOG2(WIN)) bus ();

    jt51_pg_mon #(.WIN_LOG2(WIN), .PH_STAGE(PH_STAGE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [9:0]  ph0;
        logic [9:0]  step;
        logic        rdy;
        logic [15:0] exp_res;
        logic        exp_al;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start pulse with cen low so the slot counter is not disturbed
    task automatic start_tick(input int sel);
        bus.cen      = 1'b0;
        bus.zero     = 1'b0;
        bus.slot_sel = 5'(sel);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    // One 32-slot frame, zero on the last slot; the bus carries slot s at
    // counter value (s + PH_STAGE) mod 32, other slots carry noise.
    task automatic run_frame(input int sa, input logic [9:0] pa, input int sb, input logic [9:0] pb);
        for (int k = 0; k < 32; k++) begin
            bus.cen  = 1'b1;
            bus.zero = (k == 31);
            if (k == (sa + PH_STAGE) % 32)      bus.phase = pa;
            else if (k == (sb + PH_STAGE) % 32) bus.phase = pb;
            else                                bus.phase = 10'($urandom_range(0, 1023));
            tick();
        end
        bus.cen  = 1'b0;
        bus.zero = 1'b0;
    endtask

    // Start, one arming frame, 63 measured frames, then the final frame
    task automatic measure(input int sel, input logic [9:0] ph0, input logic [9:0] step);
        logic [9:0] ph;
        ph = ph0;
        start_tick(sel);
        check("busy_after_start", bus.busy, 1);
        for (int f = 0; f < 64; f++) begin
            run_frame(sel, ph, sel, ph);
            ph = ph + step;
        end
        check("busy_before_last", bus.busy, 1);
        check("valid_before_last", bus.result_valid, 0);
        run_frame(sel, ph, sel, ph);
    endtask

    task automatic ready_pulse();
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("valid_after_ready", bus.result_valid, 0);
        check("state_after_ready", bus.dbg_state, 0);
        check("busy_after_ready", bus.busy, 0);
    endtask

    initial begin
        logic [9:0] p2;
        logic [9:0] p7;
        logic       hold_ok;
        n_cmp = 0;
        n_err = 0;

        // Reset
        rst              = 1'b1;
        bus.cen          = 1'b0;
        bus.zero         = 1'b0;
        bus.phase        = 10'd0;
        bus.slot_sel     = 5'd0;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_alias", bus.aliased, 0);
        check("rst_state", bus.dbg_state, 0);
        check("rst_cnt", bus.dbg_cnt, 0);

        // Driver table: sel, first phase, step, ready, expected sum, expected alias
        vecs[0] = '{5,  10'd0,    10'd3,   1'b1, 16'd192,   1'b0};
        vecs[1] = '{0,  10'd1000, 10'd100, 1'b0, 16'd6400,  1'b0};
        vecs[2] = '{31, 10'd0,    10'd600, 1'b0, 16'd38400, 1'b1};
        vecs[3] = '{12, 10'd7,    10'd0,   1'b0, 16'd0,     1'b0};
        vecs[4] = '{20, 10'd300,  10'd511, 1'b1, 16'd32704, 1'b0};
        vecs[5] = '{22, 10'd1,    10'd512, 1'b0, 16'd32768, 1'b1};

        for (int i = 0; i < 6; i++) begin
            bus.result_ready = vecs[i].rdy;
            measure(vecs[i].sel, vecs[i].ph0, vecs[i].step);
            check($sformatf("v%0d_result", i), bus.result, vecs[i].exp_res);
            check($sformatf("v%0d_alias", i), bus.aliased, vecs[i].exp_al);
            check($sformatf("v%0d_busy", i), bus.busy, 0);
            if (vecs[i].rdy) begin
                bus.result_ready = 1'b0;
                check($sformatf("v%0d_valid", i), bus.result_valid, 0);
                check($sformatf("v%0d_state", i), bus.dbg_state, 0);
            end else begin
                check($sformatf("v%0d_valid", i), bus.result_valid, 1);
                check($sformatf("v%0d_state", i), bus.dbg_state, 3);
                ready_pulse();
            end
        end

        // Backpressure: 200 clocks without ready, result must stay put
        bus.result_ready = 1'b0;
        measure(5, 10'd0, 10'd3);
        hold_ok = 1'b1;
        for (int c = 0; c < 200; c++) begin
            bus.cen = 1'($urandom_range(0, 1));
            tick();
            if (bus.result_valid !== 1'b1 || bus.result !== RW'(192)) hold_ok = 1'b0;
        end
        bus.cen = 1'b0;
        check("bp_hold", hold_ok, 1);
        ready_pulse();

        // Restart: slot 2 for 20 samples, then slot 7; only slot 7 counts
        p2 = 10'd100;
        p7 = 10'd900;
        start_tick(2);
        for (int f = 0; f < 21; f++) begin
            run_frame(2, p2, 7, p7);
            p2 = p2 + 10'd50;
            p7 = p7 + 10'd10;
        end
        start_tick(7);
        check("restart_state", bus.dbg_state, 1);
        for (int f = 0; f < 65; f++) begin
            run_frame(7, p7, 2, p2);
            p2 = p2 + 10'd50;
            p7 = p7 + 10'd10;
        end
        check("restart_valid", bus.result_valid, 1);
        check("restart_result", bus.result, 640);
        check("restart_alias", bus.aliased, 0);

        // Start while a result is pending drops it even with ready high
        bus.result_ready = 1'b1;
        start_tick(3);
        bus.result_ready = 1'b0;
        check("drop_valid", bus.result_valid, 0);
        check("drop_state", bus.dbg_state, 1);
        check("drop_busy", bus.busy, 1);
        check("drop_result_held", bus.result, 640);

        // Reset mid-MEASURE with cen low, counter parked mid-frame
        for (int f = 0; f < 5; f++) run_frame(3, 10'(f * 4), 3, 10'(f * 4));
        for (int k = 0; k < 10; k++) begin
            bus.cen   = 1'b1;
            bus.phase = 10'($urandom_range(0, 1023));
            tick();
        end
        bus.cen = 1'b0;
        check("pre_rst_state", bus.dbg_state, 2);
        check("pre_rst_cnt", bus.dbg_cnt, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.result_valid, 0);
        check("mid_rst_result", bus.result, 0);
        check("mid_rst_cnt", bus.dbg_cnt, 0);
        check("mid_rst_state", bus.dbg_state, 0);

        // Zero mid-frame resynchronises the counter; measurement follows it
        for (int k = 0; k < 7; k++) begin
            bus.cen = 1'b1;
            tick();
        end
        check("resync_cnt_before", bus.dbg_cnt, 7);
        bus.zero = 1'b1;
        tick();
        bus.zero = 1'b0;
        bus.cen  = 1'b0;
        check("resync_cnt_after", bus.dbg_cnt, 0);
        measure(22, 10'd50, 10'd5);
        check("resync_valid", bus.result_valid, 1);
        check("resync_result", bus.result, 320);
        ready_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
